// File: rtl/mprj_trace_pkg.sv
// rtl/mprj_trace_pkg.sv - shared types, constants and helpers for the GPIO trace block
package mprj_trace_pkg;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_TS_WIDTH = 16;
    localparam int DROP_W       = 8;

    typedef struct packed {
        logic [DEF_WIDTH-1:0]    value;
        logic [DEF_TS_WIDTH-1:0] delta;
    } trace_entry_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/mprj_io_tracer_if.sv
// rtl/mprj_io_tracer_if.sv - trace entry drain port (valid/ready with value and delta-time)
interface mprj_io_tracer_if #(
    parameter int WIDTH    = 8,
    parameter int TS_WIDTH = 16
);
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    out_data;
    logic [TS_WIDTH-1:0] out_delta;

    modport master (output out_valid, out_data, out_delta, input out_ready);
    modport slave  (input out_valid, out_data, out_delta, output out_ready);
endinterface

// File: rtl/mprj_trace_fifo.sv
// rtl/mprj_trace_fifo.sv - synchronous trace FIFO with clear, level and registered head entry
module mprj_trace_fifo
    import mprj_trace_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TS_WIDTH = DEF_TS_WIDTH,
    parameter int DEPTH    = 16
) (
    input  logic                     clk,
    input  logic                     resetb,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic [TS_WIDTH-1:0]      push_delta,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head_data,
    output logic [TS_WIDTH-1:0]      head_delta,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = WIDTH + TS_WIDTH;

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
    logic [LW-1:0] level_next;
    logic [EW-1:0] head_next;
    logic          bypass;

    assign rd_next = rd_ptr + AW'(pop);
    // A push landing on the slot that becomes head must skip the memory read.
    assign bypass    = push && (wr_ptr == rd_next);
    assign head_next = bypass ? {push_data, push_delta} : mem[rd_next];

    always_comb begin
        level_next = level;
        case ({push, pop})
            2'b10:   level_next = level + LW'(1);
            2'b01:   level_next = level - LW'(1);
            default: level_next = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !clear)
            mem[wr_ptr] <= {push_data, push_delta};
    end

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_data  <= '0;
            head_delta <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level      <= '0;
            head_data  <= '0;
            head_delta <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(push);
            rd_ptr <= rd_next;
            level  <= level_next;
            if (push || pop)
                {head_data, head_delta} <= head_next;
        end
    end

endmodule

// File: rtl/mprj_io_tracer.sv
// rtl/mprj_io_tracer.sv - GPIO change tracer with delta-time FIFO; optional arm trigger via TRACE_TRIGGER_EN
module mprj_io_tracer
    import mprj_trace_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int DEPTH    = 16,
    parameter int TS_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   resetb,
    input  logic                   enable,
    input  logic                   clear,
    input  logic [WIDTH-1:0]       io_in,
    input  logic [WIDTH-1:0]       io_mask,
    input  logic [WIDTH-1:0]       trig_mask,
    input  logic [WIDTH-1:0]       trig_value,
    mprj_io_tracer_if.master       trace,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic [DROP_W-1:0]      drop_count
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0]    s1, s2, prev;
    logic                enable_q, en_rise;
    logic                armed_now, change, evt, pop, full, push, drop;
    logic [TS_WIDTH-1:0] delta_cnt, cnt_inc, wr_delta;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            s1       <= '0;
            s2       <= '0;
            prev     <= '0;
            enable_q <= 1'b0;
        end else begin
            s1       <= io_in;
            s2       <= s1;
            prev     <= s2;
            enable_q <= enable;
        end
    end

`ifdef TRACE_TRIGGER_EN
    logic armed, arm_hit;
    assign arm_hit   = ((s2 & trig_mask) == trig_value);
    // The arming cycle's own event counts, hence the combinational OR.
    assign armed_now = enable && (armed || arm_hit);

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb)
            armed <= 1'b0;
        else if (clear || !enable)
            armed <= 1'b0;
        else if (arm_hit)
            armed <= 1'b1;
    end
`else
    logic unused_trig;
    assign unused_trig = ^{trig_mask, trig_value};
    assign armed_now   = enable;
`endif

    assign en_rise  = enable && !enable_q;
    assign change   = |((s2 ^ prev) & io_mask);
    assign evt      = armed_now && change && !clear;
    assign pop      = trace.out_valid && trace.out_ready;
    assign full     = (level == LW'(DEPTH));
    assign push     = evt && (!full || pop);
    assign drop     = evt && full && !pop;

    // Stored delta counts the write cycle itself, so it equals edges since the previous write.
    assign cnt_inc  = (&delta_cnt) ? delta_cnt : delta_cnt + TS_WIDTH'(1);
    assign wr_delta = en_rise ? '0 : cnt_inc;

    always_ff @(posedge clk or negedge resetb) begin
        if (!resetb) begin
            delta_cnt  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            delta_cnt  <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (en_rise || push)
                delta_cnt <= '0;
            else if (enable)
                delta_cnt <= cnt_inc;
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= sat_inc(drop_count);
            end
        end
    end

    mprj_trace_fifo #(
        .WIDTH    (WIDTH),
        .TS_WIDTH (TS_WIDTH),
        .DEPTH    (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetb     (resetb),
        .clear      (clear),
        .push       (push),
        .push_data  (s2),
        .push_delta (wr_delta),
        .pop        (pop),
        .head_data  (trace.out_data),
        .head_delta (trace.out_delta),
        .level      (level)
    );

    assign trace.out_valid = (level != '0);

endmodule
